// File: rtl/product_bcd_converter_pkg.sv
// Shared types and default sizes for the signed-product to BCD converter.
package product_bcd_pkg;

  // Default product width (8x8 signed multiply) and number of decimal digits.
  // NDIG_DEF must satisfy 10^NDIG_DEF > 2^(PWIDTH_DEF-1) so that every
  // magnitude, including 32768, fits in the digit array.
  localparam int PWIDTH_DEF = 16;
  localparam int NDIG_DEF   = 5;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Request/result bundle between the multiplier side (master) and the
// BCD converter (slave).
interface product_bcd_converter_if
  import product_bcd_pkg::*;
#(
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int NDIG   = NDIG_DEF
);

  logic                Start;
  logic [PWIDTH-1:0]   Prod;
  logic                Busy;
  logic                Done;
  logic                Neg;
  logic [4*NDIG-1:0]   Digits;

  // Requester: issues Start/Prod and observes the result.
  modport master (
    output Start,
    output Prod,
    input  Busy,
    input  Done,
    input  Neg,
    input  Digits
  );

  // Converter: consumes Start/Prod and publishes the result.
  modport slave (
    input  Start,
    input  Prod,
    output Busy,
    output Done,
    output Neg,
    output Digits
  );

endinterface

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import product_bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Pure combinational correction; inputs above 9 never occur in a valid run.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential two's-complement to sign + BCD converter. A Start pulse latches
// the product, the next cycle takes its magnitude, then PWIDTH shift-and-add-3
// iterations run one per clock. Digits/Neg are loaded atomically on the last
// iteration, and Done pulses for one cycle afterwards.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int NDIG   = NDIG_DEF
)(
  input  logic                    Clk,
  input  logic                    Reset,
  product_bcd_converter_if.slave  bus
);

  localparam int CW = (PWIDTH > 1) ? $clog2(PWIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(PWIDTH - 1);
  localparam int WW = 4 * NDIG + PWIDTH;

  state_t               state_reg,  state_next;
  logic [PWIDTH-1:0]    op_reg,     op_next;
  logic [PWIDTH-1:0]    mag_reg,    mag_next;
  logic                 sign_reg,   sign_next;
  logic [4*NDIG-1:0]    bcd_reg,    bcd_next;
  logic [CW-1:0]        cnt_reg,    cnt_next;
  logic [4*NDIG-1:0]    digits_reg, digits_next;
  logic                 neg_reg,    neg_next;

  logic [PWIDTH-1:0]    abs_val;
  logic [4*NDIG-1:0]    corrected;
  logic [WW-1:0]        shifted;

  // Per-digit add-3 correction of the working BCD register.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_reg[4*gi +: 4]),
      .dout (corrected[4*gi +: 4])
    );
  end

  // Magnitude of the latched operand; 0x8000 maps to 32768 as an unsigned value.
  assign abs_val = op_reg[PWIDTH-1] ? (~op_reg + PWIDTH'(1)) : op_reg;

  // One double-dabble step: {corrected bcd, mag} << 1, top bit dropped.
  assign shifted = {corrected[4*NDIG-2:0], mag_reg, 1'b0};

  // State and datapath registers; reset discards any in-flight conversion.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      mag_reg    <= '0;
      sign_reg   <= 1'b0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      digits_reg <= '0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      mag_reg    <= mag_next;
      sign_reg   <= sign_next;
      bcd_reg    <= bcd_next;
      cnt_reg    <= cnt_next;
      digits_reg <= digits_next;
      neg_reg    <= neg_next;
    end
  end

  // Next-state and datapath update; Start is only honoured in IDLE and DONE.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    mag_next    = mag_reg;
    sign_next   = sign_reg;
    bcd_next    = bcd_reg;
    cnt_next    = cnt_reg;
    digits_next = digits_reg;
    neg_next    = neg_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          op_next    = bus.Prod;
          state_next = ABS;
        end
      end

      ABS: begin
        // Zero is never reported as negative.
        sign_next  = op_reg[PWIDTH-1] && (abs_val != '0);
        mag_next   = abs_val;
        bcd_next   = '0;
        cnt_next   = '0;
        state_next = CONV;
      end

      CONV: begin
        bcd_next = shifted[WW-1:PWIDTH];
        mag_next = shifted[PWIDTH-1:0];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) begin
          // Final iteration publishes the whole result in one edge.
          digits_next = shifted[WW-1:PWIDTH];
          neg_next    = sign_reg;
          state_next  = DONE;
        end
      end

      DONE: begin
        if (bus.Start) begin
          op_next    = bus.Prod;
          state_next = ABS;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and result outputs are decoded straight from registers so that
  // reset clears them immediately.
  assign bus.Busy   = (state_reg == ABS) || (state_reg == CONV);
  assign bus.Done   = (state_reg == DONE);
  assign bus.Neg    = neg_reg;
  assign bus.Digits = digits_reg;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: table of products with
// hand-computed BCD results, plus sequences for ignored Start, back-to-back
// requests and mid-conversion reset.
module tb_product_bcd_converter;
  import product_bcd_pkg::*;

  localparam int PW = 16;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  product_bcd_converter_if #(.PWIDTH(PW), .NDIG(ND)) bus_if ();

  product_bcd_converter #(.PWIDTH(PW), .NDIG(ND)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [15:0] prod;
    logic [19:0] digits;
    logic        neg;
  } vec_t;

  vec_t vecs [8];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [19:0] hold_digits = 20'h0;
  logic        hold_neg    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a Start pulse sampled at the next edge (edge 0), then scramble Prod.
  task automatic launch(input logic [15:0] p);
    bus_if.Start = 1'b1;
    bus_if.Prod  = p;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    bus_if.Prod  = ~p ^ 16'h5A3C;
  endtask

  // From one step after edge 0, wait (bounded) for Done; k = edges elapsed.
  task automatic wait_done(output int k, output bit busy_ok, output bit hold_ok);
    k = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (bus_if.Done !== 1'b1 && k < 40) begin
      if (bus_if.Busy !== 1'b1) busy_ok = 1'b0;
      if (bus_if.Digits !== hold_digits || bus_if.Neg !== hold_neg) hold_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] p,
                         input logic [19:0] ed, input logic en);
    int k;
    bit busy_ok, hold_ok;
    launch(p);
    wait_done(k, busy_ok, hold_ok);
    check({tag, " latency"}, 32'(k), 32'd17);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, " digits"}, {12'd0, bus_if.Digits}, {12'd0, ed});
    check({tag, " neg"}, {31'd0, bus_if.Neg}, {31'd0, en});
    check({tag, " busy in done"}, {31'd0, bus_if.Busy}, 32'd0);
    $display("conv %s prod=0x%04h digits=0x%05h neg=%0b latency=%0d",
             tag, p, bus_if.Digits, bus_if.Neg, k);
    hold_digits = ed;
    hold_neg    = en;
    @(posedge clk); #1;
    check({tag, " done width"}, {31'd0, bus_if.Done}, 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    int first_k;
    bit busy_ok, hold_ok;

    vecs[0] = '{16'h0000, 20'h00000, 1'b0};
    vecs[1] = '{16'h4000, 20'h16384, 1'b0};
    vecs[2] = '{16'hFFFF, 20'h00001, 1'b1};
    vecs[3] = '{16'hC080, 20'h16256, 1'b1};
    vecs[4] = '{16'h8000, 20'h32768, 1'b1};
    vecs[5] = '{16'h7FFF, 20'h32767, 1'b0};
    vecs[6] = '{16'h0064, 20'h00100, 1'b0};
    vecs[7] = '{16'hFF9C, 20'h00100, 1'b1};

    bus_if.Start = 1'b0;
    bus_if.Prod  = 16'h0000;

    // Asynchronous reset clears outputs without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset busy",   {31'd0, bus_if.Busy},   32'd0);
    check("reset done",   {31'd0, bus_if.Done},   32'd0);
    check("reset neg",    {31'd0, bus_if.Neg},    32'd0);
    check("reset digits", {12'd0, bus_if.Digits}, 32'd0);
    $display("reset applied");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].prod, vecs[i].digits, vecs[i].neg);
    end

    // Start pulses while busy are ignored: one Done, result for 0x0019.
    launch(16'h0019);
    k = 0; dones = 0; first_k = -1; hold_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus_if.Start = (k == 4 || k == 9);
      bus_if.Prod  = (k == 4 || k == 9) ? 16'h0333 : 16'h1111;
      if (k < 17 && (bus_if.Digits !== hold_digits || bus_if.Neg !== hold_neg)) hold_ok = 1'b0;
      @(posedge clk); #1;
      k++;
      if (bus_if.Done === 1'b1) begin
        dones++;
        if (first_k < 0) first_k = k;
      end
    end
    bus_if.Start = 1'b0;
    check("ignore done count", 32'(dones), 32'd1);
    check("ignore latency", 32'(first_k), 32'd17);
    check("ignore hold", {31'd0, hold_ok}, 32'd1);
    check("ignore digits", {12'd0, bus_if.Digits}, 32'h00025);
    check("ignore neg", {31'd0, bus_if.Neg}, 32'd0);
    check("ignore idle", {31'd0, bus_if.Busy}, 32'd0);
    $display("conv ignore-start prod=0x0019 digits=0x%05h dones=%0d", bus_if.Digits, dones);
    hold_digits = 20'h00025;
    hold_neg    = 1'b0;

    // Back-to-back: Start in the Done cycle is accepted with no idle gap.
    launch(16'h0032);
    wait_done(k, busy_ok, hold_ok);
    check("b2b first latency", 32'(k), 32'd17);
    check("b2b first digits", {12'd0, bus_if.Digits}, 32'h00050);
    hold_digits = 20'h00050;
    bus_if.Start = 1'b1;
    bus_if.Prod  = 16'h0064;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    bus_if.Prod  = 16'h0000;
    check("b2b no gap busy", {31'd0, bus_if.Busy}, 32'd1);
    check("b2b no gap done", {31'd0, bus_if.Done}, 32'd0);
    wait_done(k, busy_ok, hold_ok);
    check("b2b second latency", 32'(k), 32'd17);
    check("b2b second busy", {31'd0, busy_ok}, 32'd1);
    check("b2b second hold", {31'd0, hold_ok}, 32'd1);
    check("b2b second digits", {12'd0, bus_if.Digits}, 32'h00100);
    check("b2b second neg", {31'd0, bus_if.Neg}, 32'd0);
    $display("conv back-to-back prod=0x0064 digits=0x%05h latency=%0d", bus_if.Digits, k);
    hold_digits = 20'h00100;
    @(posedge clk); #1;

    // Reset mid-conversion: immediate clear, no Done afterwards.
    launch(16'h1234);
    repeat (8) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst busy",   {31'd0, bus_if.Busy},   32'd0);
    check("midrst done",   {31'd0, bus_if.Done},   32'd0);
    check("midrst neg",    {31'd0, bus_if.Neg},    32'd0);
    check("midrst digits", {12'd0, bus_if.Digits}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus_if.Done === 1'b1) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);
    $display("reset mid-conversion prod=0x1234 dones_after=%0d", dones);
    hold_digits = 20'h0;
    hold_neg    = 1'b0;
    convert("after-reset", 16'h0007, 20'h00007, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
